// File: rtl/blk_pkg.sv
// Shared defaults, scan state encoding and the block-to-pixel shift-add helper
// for the block position scanner.
package blk_pkg;

  localparam int BLK_SIZE_DEF = 24;
  localparam int NUM_BLKS_DEF = 24;
  localparam int H_TOTAL_DEF  = 800;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_OUT    = 2'd2
  } state_t;

  // Column of (block, offset): one shifted copy of the block index per set bit
  // of blk_size, so 24 becomes (b<<4)+(b<<3)+o without a multiplier.
  function automatic logic [9:0] blk_to_pix(input logic [4:0] b,
                                            input logic [4:0] o,
                                            input int unsigned blk_size);
    logic [9:0] acc;
    logic [9:0] bw;
    bw  = {5'b0, b};
    acc = {5'b0, o};
    for (int i = 0; i < 10; i++) begin
      if (blk_size[i]) acc = acc + (bw << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/blk_mod_counter.sv
// Modulo-MOD counter with clear, load and carry-out; used for the pixel offset
// within a block and for the row offset within a block row.
module blk_mod_counter #(
  parameter int MOD = 24,
  parameter int W   = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_inc,
  output logic [W-1:0] o_count,
  output logic [W-1:0] o_next,
  output logic         o_carry
);

  localparam logic [W-1:0] L_LAST = W'(MOD - 1);

  logic [W-1:0] r_count;

  always_comb begin
    o_carry = 1'b0;
    o_next  = r_count;
    if (i_clr) begin
      o_next = '0;
    end else if (i_load) begin
      o_next = i_load_val;
    end else if (i_inc) begin
      if (r_count == L_LAST) begin
        o_next  = '0;
        o_carry = 1'b1;
      end else begin
        o_next = r_count + W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_count <= '0;
    else        r_count <= o_next;
  end

  assign o_count = r_count;

endmodule

// File: rtl/blkpos_scanner.sv
// Tracks pixel column, block index and in-block offset along a video line, with seek.
// Define BLKSCAN_VERT_EN to add row tracking (vblkid/voffset); otherwise they are 0.
module blkpos_scanner
  import blk_pkg::*;
#(
  parameter int BLK_SIZE = BLK_SIZE_DEF,
  parameter int NUM_BLKS = NUM_BLKS_DEF,
  parameter int H_TOTAL  = H_TOTAL_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  input  logic       line_start,
  input  logic       frame_start,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [4:0] blkid_in,
  input  logic [4:0] offset_in,
  output logic [9:0] pposition,
  output logic [4:0] blkid,
  output logic [4:0] offset,
  output logic       in_field,
  output logic       blk_first,
  output logic       blk_last,
  output logic       load_err,
  output logic [4:0] vblkid,
  output logic [4:0] voffset
);

  localparam logic [4:0] L_OFF_LAST  = 5'(BLK_SIZE - 1);
  localparam logic [4:0] L_NUM_BLKS  = 5'(NUM_BLKS);
  localparam logic [4:0] L_BLK_LAST  = 5'(NUM_BLKS - 1);
  localparam logic [5:0] L_BLK_SIZE6 = 6'(BLK_SIZE);
  localparam logic [5:0] L_NUM_BLKS6 = 6'(NUM_BLKS);
  localparam logic [9:0] L_H_TOTAL   = 10'(H_TOTAL);
  localparam logic [9:0] L_FIELD_END = 10'(NUM_BLKS * BLK_SIZE);

  state_t     r_state, w_state_next;
  logic [9:0] r_pposition, w_pp_next, w_pp_inc;
  logic [4:0] r_blkid, w_blkid_next;
  logic       r_in_field, r_blk_first, r_blk_last, r_load_err;
  logic       w_seek, w_seek_bad, w_seek_oob, w_seek_ok;
  logic       w_step, w_hwrap;
  logic       w_off_clr, w_off_inc, w_off_carry;
  logic [4:0] w_off_next;
  logic       w_in_field_next;

  assign load_ready = ~line_start;

  assign w_seek     = load_valid & load_ready;
  assign w_seek_bad = w_seek & ({1'b0, offset_in} >= L_BLK_SIZE6);
  assign w_seek_oob = w_seek & ~w_seek_bad & ({1'b0, blkid_in} >= L_NUM_BLKS6);
  assign w_seek_ok  = w_seek & ~w_seek_bad & ~w_seek_oob;

  // Any seek, even a rejected one, swallows a coincident pixel strobe.
  assign w_step   = pix_en & ~line_start & ~w_seek & (r_state != ST_IDLE);
  assign w_pp_inc = r_pposition + 10'd1;
  assign w_hwrap  = w_step & (w_pp_inc == L_H_TOTAL);

  assign w_off_clr = line_start | w_seek_oob | w_hwrap | (w_step & (r_state == ST_OUT));
  assign w_off_inc = w_step & (r_state == ST_ACTIVE);

  blk_mod_counter #(.MOD(BLK_SIZE), .W(5)) u_hcnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_off_clr),
    .i_load    (w_seek_ok),
    .i_load_val(offset_in),
    .i_inc     (w_off_inc),
    .o_count   (offset),
    .o_next    (w_off_next),
    .o_carry   (w_off_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_pp_next    = r_pposition;
    w_blkid_next = r_blkid;
    if (line_start) begin
      w_state_next = ST_ACTIVE;
      w_pp_next    = '0;
      w_blkid_next = '0;
    end else if (w_seek_ok) begin
      w_state_next = ST_ACTIVE;
      w_pp_next    = blk_to_pix(blkid_in, offset_in, BLK_SIZE);
      w_blkid_next = blkid_in;
    end else if (w_seek_oob) begin
      w_state_next = ST_OUT;
      w_pp_next    = L_FIELD_END;
      w_blkid_next = L_NUM_BLKS;
    end else if (w_hwrap) begin
      w_state_next = ST_ACTIVE;
      w_pp_next    = '0;
      w_blkid_next = '0;
    end else if (w_step) begin
      w_pp_next = w_pp_inc;
      if (r_state == ST_ACTIVE && w_off_carry) begin
        w_blkid_next = r_blkid + 5'd1;
        if (r_blkid == L_BLK_LAST) w_state_next = ST_OUT;
      end
    end
  end

  assign w_in_field_next = ({1'b0, w_blkid_next} < L_NUM_BLKS6);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pposition <= '0;
      r_blkid     <= '0;
      r_in_field  <= 1'b0;
      r_blk_first <= 1'b0;
      r_blk_last  <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_pposition <= w_pp_next;
      r_blkid     <= w_blkid_next;
      r_in_field  <= w_in_field_next;
      r_blk_first <= w_in_field_next & (w_off_next == 5'd0);
      r_blk_last  <= w_in_field_next & (w_off_next == L_OFF_LAST);
      r_load_err  <= w_seek_bad;
    end
  end

  assign pposition = r_pposition;
  assign blkid     = r_blkid;
  assign in_field  = r_in_field;
  assign blk_first = r_blk_first;
  assign blk_last  = r_blk_last;
  assign load_err  = r_load_err;

`ifdef BLKSCAN_VERT_EN
  logic       w_vcarry;
  logic [4:0] w_voff_next_unused;
  logic [4:0] r_vblkid;

  blk_mod_counter #(.MOD(BLK_SIZE), .W(5)) u_vcnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (frame_start),
    .i_load    (1'b0),
    .i_load_val(5'd0),
    .i_inc     (line_start),
    .o_count   (voffset),
    .o_next    (w_voff_next_unused),
    .o_carry   (w_vcarry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                r_vblkid <= '0;
    else if (frame_start)                      r_vblkid <= '0;
    else if (w_vcarry && r_vblkid != L_NUM_BLKS) r_vblkid <= r_vblkid + 5'd1;
  end

  assign vblkid = r_vblkid;
`else
  logic w_frame_unused;
  assign w_frame_unused = frame_start;
  assign vblkid         = '0;
  assign voffset        = '0;
`endif

endmodule

// File: tb/tb_blkpos_scanner.sv
// Directed bench for blkpos_scanner: line scan, field end, line wrap, seeks,
// priorities, optional row tracking and mid-line reset.
module tb_blkpos_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pix_en, line_start, frame_start, load_valid, load_ready;
  logic [4:0] blkid_in, offset_in;
  logic [9:0] pposition;
  logic [4:0] blkid, offset, vblkid, voffset;
  logic       in_field, blk_first, blk_last, load_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  blkpos_scanner dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_en     (pix_en),
    .line_start (line_start),
    .frame_start(frame_start),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .blkid_in   (blkid_in),
    .offset_in  (offset_in),
    .pposition  (pposition),
    .blkid      (blkid),
    .offset     (offset),
    .in_field   (in_field),
    .blk_first  (blk_first),
    .blk_last   (blk_last),
    .load_err   (load_err),
    .vblkid     (vblkid),
    .voffset    (voffset)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int n);
    pix_en = 1'b1;
    repeat (n) tick();
    pix_en = 1'b0;
  endtask

  task automatic pulse_line();
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic seek(input logic [4:0] b, input logic [4:0] o);
    load_valid = 1'b1;
    blkid_in   = b;
    offset_in  = o;
    tick();
    load_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; pix_en = 1'b0; line_start = 1'b0; frame_start = 1'b0;
    load_valid = 1'b0; blkid_in = '0; offset_in = '0;
    tick(); tick();
    check("rst_pposition", pposition, 0);
    check("rst_blkid", blkid, 0);
    check("rst_offset", offset, 0);
    check("rst_in_field", in_field, 0);
    check("rst_blk_first", blk_first, 0);
    check("rst_load_err", load_err, 0);
    rst_n = 1'b1;
    tick();

    pix(3);
    check("idle_ignores_pix", pposition, 0);

    pulse_line();
    check("ls_pposition", pposition, 0);
    check("ls_in_field", in_field, 1);
    check("ls_blk_first", blk_first, 1);

    pix(23);
    check("p23_offset", offset, 23);
    check("p23_blk_last", blk_last, 1);
    pix(1);
    check("p24_pposition", pposition, 24);
    check("p24_blkid", blkid, 1);
    check("p24_offset", offset, 0);
    check("p24_blk_first", blk_first, 1);

    pix(552);
    check("p576_pposition", pposition, 576);
    check("p576_blkid", blkid, 24);
    check("p576_offset", offset, 0);
    check("p576_in_field", in_field, 0);
    check("p576_blk_first", blk_first, 0);
    pix(223);
    check("p799_pposition", pposition, 799);
    check("p799_blkid", blkid, 24);
    pix(1);
    check("p800_pposition", pposition, 0);
    check("p800_blkid", blkid, 0);
    check("p800_in_field", in_field, 1);

    load_valid = 1'b1; blkid_in = 5'd5; offset_in = 5'd7;
    #1;
    check("seek_load_ready", load_ready, 1);
    tick();
    load_valid = 1'b0;
    check("seek_pposition", pposition, 127);
    check("seek_blkid", blkid, 5);
    check("seek_offset", offset, 7);
    pix(1);
    check("seek_pix_pposition", pposition, 128);
    check("seek_pix_offset", offset, 8);

    seek(5'd2, 5'd24);
    check("bad_load_err", load_err, 1);
    check("bad_pposition", pposition, 128);
    check("bad_blkid", blkid, 5);
    check("bad_offset", offset, 8);
    tick();
    check("bad_load_err_drop", load_err, 0);

    seek(5'd30, 5'd3);
    check("oob_pposition", pposition, 576);
    check("oob_blkid", blkid, 24);
    check("oob_in_field", in_field, 0);

    pix_en = 1'b1;
    seek(5'd2, 5'd23);
    pix_en = 1'b0;
    check("seekpix_pposition", pposition, 71);
    check("seekpix_blk_last", blk_last, 1);

    load_valid = 1'b1; line_start = 1'b1; blkid_in = 5'd5; offset_in = 5'd7;
    #1;
    check("ls_seek_load_ready", load_ready, 0);
    tick();
    load_valid = 1'b0; line_start = 1'b0;
    check("ls_seek_pposition", pposition, 0);
    check("ls_seek_blkid", blkid, 0);
    check("ls_seek_offset", offset, 0);

`ifdef BLKSCAN_VERT_EN
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("fs_vblkid", vblkid, 0);
    check("fs_voffset", voffset, 0);
    line_start = 1'b1;
    repeat (25) tick();
    line_start = 1'b0;
    check("v25_vblkid", vblkid, 1);
    check("v25_voffset", voffset, 1);
    frame_start = 1'b1; line_start = 1'b1;
    tick();
    frame_start = 1'b0; line_start = 1'b0;
    check("fs_prio_vblkid", vblkid, 0);
    check("fs_prio_voffset", voffset, 0);
`else
    pulse_line();
    check("novert_vblkid", vblkid, 0);
    check("novert_voffset", voffset, 0);
`endif

    pix(10);
    check("pre_rst_pposition", pposition, 10);
    rst_n = 1'b0;
    #1;
    check("midrst_pposition", pposition, 0);
    check("midrst_offset", offset, 0);
    check("midrst_in_field", in_field, 0);
    check("midrst_vblkid", vblkid, 0);
    check("midrst_voffset", voffset, 0);
    tick();
    rst_n = 1'b1;
    tick();
    pix(5);
    check("postrst_ignored", pposition, 0);
    pulse_line();
    pix(2);
    check("postrst_resume", pposition, 2);
    check("postrst_offset", offset, 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/blkpos_scanner.md
BLKPOS_SCANNER -- requirements
Module: blkpos_scanner

Interface
REQ-001 SHALL have parameter BLK_SIZE, default 24, block width in pixels.
REQ-002 SHALL have parameter NUM_BLKS, default 24, number of blocks across the field.
REQ-003 SHALL have parameter H_TOTAL, default 800, pixels per line, including blanking.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port pix_en, input, 1 bit, pixel strobe; advances the scan by one pixel.
REQ-007 SHALL have port line_start, input, 1 bit, restarts the line at pixel 0.
REQ-008 SHALL have port frame_start, input, 1 bit, restarts the vertical count.
REQ-009 SHALL have port load_valid, input, 1 bit, requests a seek to a block coordinate.
REQ-010 SHALL have port load_ready, output, 1 bit, seek accepted when both load_valid and load_ready are high.
REQ-011 SHALL have port blkid_in, input, 5 bits, seek block index.
REQ-012 SHALL have port offset_in, input, 5 bits, seek offset within the block.
REQ-013 SHALL have port pposition, output, 10 bits, current pixel column.
REQ-014 SHALL have port blkid, output, 5 bits, current block index.
REQ-015 SHALL have port offset, output, 5 bits, pixel offset within the block, range 0..BLK_SIZE-1.
REQ-016 SHALL have port in_field, output, 1 bit, high when blkid < NUM_BLKS.
REQ-017 SHALL have port blk_first and blk_last, outputs, 1 bit each: offset==0 and offset==BLK_SIZE-1 while in_field.
REQ-018 SHALL have port load_err, output, 1 bit, one-cycle pulse when a seek is rejected.
REQ-019 SHALL have ports vblkid (5 bits) and voffset (5 bits), outputs, row block index and row offset.

Function
REQ-020 SHALL register all outputs except load_ready; an event in cycle n is visible in cycle n+1.
REQ-021 SHALL use states IDLE, ACTIVE and OUT:
  - IDLE: from reset; line_start moves to ACTIVE.
  - ACTIVE: offset reaching BLK_SIZE-1 with blkid==NUM_BLKS-1 moves to OUT on the next pix_en.
  - OUT: line_start moves to ACTIVE.
REQ-022 SHALL, on pix_en in ACTIVE:
  - increment pposition;
  - increment offset; at BLK_SIZE-1, wrap offset to 0 and increment blkid.
REQ-023 SHALL, on pix_en in OUT, increment pposition and hold blkid=NUM_BLKS and offset=0.
REQ-024 SHALL, when pposition would reach H_TOTAL, wrap pposition, blkid and offset to 0 and enter ACTIVE.
REQ-025 SHALL ignore pix_en in IDLE.
REQ-026 SHALL, on line_start, clear pposition, blkid and offset to 0 regardless of state.
REQ-027 SHALL drive load_ready = ~line_start, combinationally.
REQ-028 SHALL give line_start priority over a seek and a seek priority over pix_en in the same cycle.
REQ-029 SHALL, on an accepted seek with offset_in < BLK_SIZE and blkid_in < NUM_BLKS:
  - load blkid and offset from the inputs;
  - set pposition = blkid_in*BLK_SIZE + offset_in, computed by shift-add (16b+8b+o for 24), 10-bit;
  - enter ACTIVE.
REQ-030 SHALL, on an accepted seek with blkid_in >= NUM_BLKS, enter OUT with pposition = NUM_BLKS*BLK_SIZE, blkid=NUM_BLKS and offset=0.
REQ-031 SHALL, on an accepted seek with offset_in >= BLK_SIZE, pulse load_err and leave all state unchanged.

Reset
REQ-032 SHALL, while rst_n is low, set state to IDLE and clear pposition, blkid, offset, vblkid, voffset, in_field, blk_first, blk_last and load_err to 0.
REQ-033 SHALL, when reset is asserted mid-line, abandon the line; counting resumes only after line_start.

Configuration
REQ-034 SHALL, with BLKSCAN_VERT_EN defined, provide vertical row tracking:
  - line_start advances voffset modulo BLK_SIZE, carrying into vblkid;
  - vblkid saturates at NUM_BLKS;
  - frame_start clears both; frame_start has priority over line_start.
REQ-035 SHALL, with BLKSCAN_VERT_EN undefined, tie vblkid and voffset to 0 and instantiate no vertical logic.

Structure
REQ-036 SHALL place BLK_SIZE, NUM_BLKS, H_TOTAL defaults and the state enum in a shared package blk_pkg.
REQ-037 SHALL implement the mod-BLK_SIZE offset counter with carry as sub-module blk_mod_counter, reused for the vertical counter.

Verification
REQ-038 SHALL cover: line_start then 24 pix_en -> pposition=24, blkid=1, offset=0, blk_first=1.
REQ-039 SHALL cover: line_start then 576 pix_en -> state OUT, blkid=24, in_field=0; after 800 total pix_en -> pposition=0, blkid=0.
REQ-040 SHALL cover: seek blkid_in=5, offset_in=7 -> next cycle pposition=127, blkid=5, offset=7; then one pix_en -> 128.
REQ-041 SHALL cover: seek offset_in=24 -> load_err=1 for one cycle, outputs unchanged; seek with line_start high -> load_ready=0, line restarts to 0.
REQ-042 SHALL cover: with BLKSCAN_VERT_EN defined, frame_start then 25 line_start -> vblkid=1, voffset=1; rst_n low mid-line -> all outputs 0, pix_en ignored until line_start.
